// File: rtl/cart_mbc_if.sv
// CPU-side bus of the cartridge mapper: address/data/strobe toward the
// mapper, mapped ROM/RAM addresses, chip selects and RTC read data back.
interface cart_mbc_if #(
  parameter int ROM_ADDR_WIDTH = 21,
  parameter int RAM_ADDR_WIDTH = 15
);
  logic [15:0]               addr;
  logic [7:0]                data_in;
  logic                      wr;
  logic                      rtc_tick;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic                      ram_cs;
  logic                      rtc_cs;
  logic [7:0]                rtc_data_out;

  modport master (
    output addr, data_in, wr, rtc_tick,
    input  rom_addr, ram_addr, ram_cs, rtc_cs, rtc_data_out
  );

  modport slave (
    input  addr, data_in, wr, rtc_tick,
    output rom_addr, ram_addr, ram_cs, rtc_cs, rtc_data_out
  );
endinterface

// File: rtl/cart_mbc.sv
// Game cartridge memory bank controller: decodes CPU writes into banking
// registers (none / MBC1 / MBC3 with real-time clock / MBC5) and maps the
// CPU address onto external ROM and cart-RAM byte addresses.
module cart_mbc #(
  parameter int MBC_TYPE       = 3,
  parameter int ROM_ADDR_WIDTH = 21,
  parameter int RAM_ADDR_WIDTH = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  cart_mbc_if.slave  bus
);

  localparam logic HAS_MAPPER = (MBC_TYPE != 0);
  localparam logic IS_MBC1    = (MBC_TYPE == 1);
  localparam logic IS_MBC3    = (MBC_TYPE == 3);
  localparam logic IS_MBC5    = (MBC_TYPE == 5);

  // RTC register file index: 0=S 1=M 2=H 3=DL 4=DH (CPU codes 08..0C)
  logic       ram_enable_q, ram_enable_d;
  logic [8:0] rom_bank_q, rom_bank_d;
  logic [1:0] upper_q, upper_d;
  logic       mode_q, mode_d;
  logic [3:0] ram_bank_q, ram_bank_d;
  logic       rtc_sel_q, rtc_sel_d;
  logic [2:0] rtc_idx_q, rtc_idx_d;
  logic       latch_armed_q, latch_armed_d;
  logic [7:0] rtc_live_q [5];
  logic [7:0] rtc_live_d [5];
  logic [7:0] rtc_lat_q  [5];
  logic [7:0] rtc_lat_d  [5];

  logic       in_ext;
  logic       rtc_cs_w;
  logic       rtc_wr;
  logic       latch_now;
  logic [8:0] day;
  logic [8:0] eff_bank;
  logic [3:0] ram_bank_eff;

  assign in_ext   = (bus.addr[15:13] == 3'b101);
  assign rtc_cs_w = IS_MBC3 & ram_enable_q & in_ext & rtc_sel_q;
  assign day      = {rtc_live_q[4][0], rtc_live_q[3]};

  // Register-write decode, RTC load/count and latch sequencing
  always_comb begin
    ram_enable_d  = ram_enable_q;
    rom_bank_d    = rom_bank_q;
    upper_d       = upper_q;
    mode_d        = mode_q;
    ram_bank_d    = ram_bank_q;
    rtc_sel_d     = rtc_sel_q;
    rtc_idx_d     = rtc_idx_q;
    latch_armed_d = latch_armed_q;
    rtc_live_d    = rtc_live_q;
    rtc_lat_d     = rtc_lat_q;
    rtc_wr        = 1'b0;
    latch_now     = 1'b0;

    if (bus.wr && HAS_MAPPER) begin
      case (bus.addr[15:13])
        3'b000: ram_enable_d = (bus.data_in[3:0] == 4'hA);
        3'b001: begin
          if (IS_MBC1) begin
            rom_bank_d = {4'd0, (bus.data_in[4:0] == 5'd0) ? 5'd1 : bus.data_in[4:0]};
          end else if (IS_MBC3) begin
            rom_bank_d = {2'd0, (bus.data_in[6:0] == 7'd0) ? 7'd1 : bus.data_in[6:0]};
          end else if (IS_MBC5) begin
            if (!bus.addr[12]) rom_bank_d[7:0] = bus.data_in;
            else               rom_bank_d[8]   = bus.data_in[0];
          end
        end
        3'b010: begin
          if (IS_MBC1) begin
            upper_d = bus.data_in[1:0];
          end else if (IS_MBC5) begin
            ram_bank_d = bus.data_in[3:0];
          end else if (IS_MBC3) begin
            if (bus.data_in <= 8'h03) begin
              ram_bank_d = {2'd0, bus.data_in[1:0]};
              rtc_sel_d  = 1'b0;
            end else if (bus.data_in >= 8'h08 && bus.data_in <= 8'h0C) begin
              rtc_idx_d = bus.data_in[2:0];
              rtc_sel_d = 1'b1;
            end
          end
        end
        3'b011: begin
          if (IS_MBC1) begin
            mode_d = bus.data_in[0];
          end else if (IS_MBC3) begin
            if (bus.data_in == 8'h00) begin
              latch_armed_d = 1'b1;
            end else begin
              latch_armed_d = 1'b0;
              latch_now     = (bus.data_in == 8'h01) && latch_armed_q;
            end
          end
        end
        3'b101: rtc_wr = rtc_cs_w;
        default: ;
      endcase
    end

    if (latch_now) rtc_lat_d = rtc_live_q;

    // A CPU load of an RTC register wins over a coincident tick
    if (rtc_wr) begin
      case (rtc_idx_q)
        3'd0:    rtc_live_d[0] = bus.data_in & 8'h3F;
        3'd1:    rtc_live_d[1] = bus.data_in & 8'h3F;
        3'd2:    rtc_live_d[2] = bus.data_in & 8'h1F;
        3'd3:    rtc_live_d[3] = bus.data_in;
        default: rtc_live_d[4] = bus.data_in & 8'hC1;
      endcase
    end else if (IS_MBC3 && bus.rtc_tick && !rtc_live_q[4][6]) begin
      if (rtc_live_q[0] != 8'd59) begin
        rtc_live_d[0] = (rtc_live_q[0] + 8'd1) & 8'h3F;
      end else begin
        rtc_live_d[0] = 8'd0;
        if (rtc_live_q[1] != 8'd59) begin
          rtc_live_d[1] = (rtc_live_q[1] + 8'd1) & 8'h3F;
        end else begin
          rtc_live_d[1] = 8'd0;
          if (rtc_live_q[2] != 8'd23) begin
            rtc_live_d[2] = (rtc_live_q[2] + 8'd1) & 8'h1F;
          end else begin
            rtc_live_d[2] = 8'd0;
            if (day == 9'h1FF) begin
              rtc_live_d[3]    = 8'd0;
              rtc_live_d[4][0] = 1'b0;
              rtc_live_d[4][7] = 1'b1;
            end else begin
              {rtc_live_d[4][0], rtc_live_d[3]} = day + 9'd1;
            end
          end
        end
      end
    end
  end

  // State registers; reset returns the cartridge to its power-on mapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_enable_q  <= 1'b0;
      rom_bank_q    <= 9'd1;
      upper_q       <= 2'd0;
      mode_q        <= 1'b0;
      ram_bank_q    <= 4'd0;
      rtc_sel_q     <= 1'b0;
      rtc_idx_q     <= 3'd0;
      latch_armed_q <= 1'b0;
      rtc_live_q    <= '{default: 8'h00};
      rtc_lat_q     <= '{default: 8'h00};
    end else begin
      ram_enable_q  <= ram_enable_d;
      rom_bank_q    <= rom_bank_d;
      upper_q       <= upper_d;
      mode_q        <= mode_d;
      ram_bank_q    <= ram_bank_d;
      rtc_sel_q     <= rtc_sel_d;
      rtc_idx_q     <= rtc_idx_d;
      latch_armed_q <= latch_armed_d;
      rtc_live_q    <= rtc_live_d;
      rtc_lat_q     <= rtc_lat_d;
    end
  end

  assign eff_bank     = IS_MBC1 ? {2'd0, upper_q, rom_bank_q[4:0]} : rom_bank_q;
  assign ram_bank_eff = IS_MBC1 ? (mode_q ? {2'd0, upper_q} : 4'd0) : ram_bank_q;

  // ROM mapping: fixed window below 4000, switchable bank above
  always_comb begin
    if (!HAS_MAPPER) begin
      bus.rom_addr = ROM_ADDR_WIDTH'(bus.addr[14:0]);
    end else if (!bus.addr[14]) begin
      if (IS_MBC1 && mode_q) bus.rom_addr = ROM_ADDR_WIDTH'({upper_q, 5'd0, bus.addr[13:0]});
      else                   bus.rom_addr = ROM_ADDR_WIDTH'(bus.addr[13:0]);
    end else begin
      bus.rom_addr = ROM_ADDR_WIDTH'({eff_bank, bus.addr[13:0]});
    end
  end

  assign bus.ram_addr     = RAM_ADDR_WIDTH'({ram_bank_eff, bus.addr[12:0]});
  assign bus.ram_cs       = HAS_MAPPER & ram_enable_q & in_ext & !rtc_sel_q;
  assign bus.rtc_cs       = rtc_cs_w;
  assign bus.rtc_data_out = rtc_sel_q ? rtc_lat_q[rtc_idx_q] : 8'hFF;

endmodule
